// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, packer state encoding and the byte-swap helper
package aes_pkg;

    localparam int AES_BLOCK_WIDTH     = 128;
    localparam int AES_WORD_WIDTH      = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } pack_state_t;

    function automatic logic [AES_WORD_WIDTH-1:0] byte_swap(input logic [AES_WORD_WIDTH-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_block_slot.sv
// aes_block_slot: single-entry valid/ready holding register with a transfer counter
// Ports: iClk, iRst (sync, active-high), iLoad/iData load a new entry,
//        iReady consumer accept, oValid/oData held entry, oFree slot can take a load
//        this cycle, oCnt transfers since reset (wraps).
module aes_block_slot #(
    parameter int W         = 128,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iLoad,
    input  logic [W-1:0]         iData,
    input  logic                 iReady,
    output logic                 oValid,
    output logic [W-1:0]         oData,
    output logic                 oFree,
    output logic [CNT_WIDTH-1:0] oCnt
);

    logic xfer;

    assign xfer  = oValid && iReady;
    assign oFree = !oValid || iReady;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid <= 1'b0;
            oData  <= '0;
            oCnt   <= '0;
        end else begin
            if (iLoad) begin
                oValid <= 1'b1;
                oData  <= iData;
            end else if (xfer) begin
                oValid <= 1'b0;
            end
            if (xfer)
                oCnt <= oCnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_word_packer.sv
// aes_word_packer: packs four 32-bit words (first word = MSW) into a 128-bit AES block
// Ports: iClk, iRst (sync, active-high), iClear (soft clear, same as iRst),
//        iWrite/iData word input, oFull input stall, oUsedw words held (0..8),
//        oBlock_valid/oBlock/iBlock_ready block handshake, oBlock_cnt blocks handed off,
//        oErr_overflow sticky write-while-full flag.
// Macro AES_PACK_BYTESWAP_EN: byte-reverse each input word before storage.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 128,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iClear,
    input  logic                   iWrite,
    input  logic [DATA_WIDTH-1:0]  iData,
    output logic                   oFull,
    output logic [3:0]             oUsedw,
    output logic                   oBlock_valid,
    output logic [BLOCK_WIDTH-1:0] oBlock,
    input  logic                   iBlock_ready,
    output logic [CNT_WIDTH-1:0]   oBlock_cnt,
    output logic                   oErr_overflow
);

    pack_state_t                state, state_next;
    logic [1:0]                 idx, idx_next;
    logic [AES_BLOCK_WIDTH-1:0] asm_q, asm_next;
    logic [AES_WORD_WIDTH-1:0]  word;
    logic [3:0]                 usedw_next;
    logic                       rst, accept, last, slot_free, xfer, load, valid_next;

    assign rst = iRst || iClear;

`ifdef AES_PACK_BYTESWAP_EN
    assign word = byte_swap(iData);
`else
    assign word = iData;
`endif

    assign oFull = (state == PENDING);

    always_comb begin
        accept   = iWrite && state == FILL;
        last     = accept && idx == 2'd3;
        xfer     = oBlock_valid && iBlock_ready;
        // A held block leaves PENDING on the same edge the output slot is consumed.
        load     = (last && slot_free) || (state == PENDING && xfer);
        idx_next = accept ? idx + 2'd1 : idx;
        asm_next = asm_q;
        for (int k = 0; k < AES_WORDS_PER_BLOCK; k++)
            if (accept && idx == k[1:0])
                asm_next[AES_BLOCK_WIDTH-1-AES_WORD_WIDTH*k -: AES_WORD_WIDTH] = word;
        state_next = state;
        if (last && !slot_free)
            state_next = PENDING;
        else if (state == PENDING && xfer)
            state_next = FILL;
        valid_next = load || (oBlock_valid && !xfer);
        usedw_next = {2'b00, idx_next} + (state_next == PENDING ? 4'd4 : 4'd0) + (valid_next ? 4'd4 : 4'd0);
    end

    always_ff @(posedge iClk) begin
        if (rst) begin
            state         <= FILL;
            idx           <= '0;
            asm_q         <= '0;
            oUsedw        <= '0;
            oErr_overflow <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            asm_q  <= asm_next;
            oUsedw <= usedw_next;
            if (iWrite && state == PENDING)
                oErr_overflow <= 1'b1;
        end
    end

    aes_block_slot #(
        .W         (BLOCK_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot (
        .iClk   (iClk),
        .iRst   (rst),
        .iLoad  (load),
        .iData  (asm_next),
        .iReady (iBlock_ready),
        .oValid (oBlock_valid),
        .oData  (oBlock),
        .oFree  (slot_free),
        .oCnt   (oBlock_cnt)
    );

endmodule

// File: tb/tb_aes_word_packer.sv
// tb_aes_word_packer: directed self-checking bench for aes_word_packer
module tb_aes_word_packer;

    logic         iClk = 1'b0;
    logic         iRst = 1'b0;
    logic         iClear = 1'b0;
    logic         iWrite = 1'b0;
    logic [31:0]  iData = '0;
    logic         oFull;
    logic [3:0]   oUsedw;
    logic         oBlock_valid;
    logic [127:0] oBlock;
    logic         iBlock_ready = 1'b0;
    logic [15:0]  oBlock_cnt;
    logic         oErr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    aes_word_packer dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iClear        (iClear),
        .iWrite        (iWrite),
        .iData         (iData),
        .oFull         (oFull),
        .oUsedw        (oUsedw),
        .oBlock_valid  (oBlock_valid),
        .oBlock        (oBlock),
        .iBlock_ready  (iBlock_ready),
        .oBlock_cnt    (oBlock_cnt),
        .oErr_overflow (oErr_overflow)
    );

    function automatic logic [31:0] fx(input logic [31:0] w);
`ifdef AES_PACK_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] blk(input logic [31:0] a, b, c, d);
        return {fx(a), fx(b), fx(c), fx(d)};
    endfunction

    function automatic logic [31:0] sw(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        iWrite = 1'b1;
        iData  = d;
        tick();
        iWrite = 1'b0;
    endtask

    initial begin
        int sent, rcv, cyc;
        // Reset state
        iRst = 1'b1;
        tick();
        tick();
        iRst = 1'b0;
        chk("rst_valid", 128'(oBlock_valid), 128'd0);
        chk("rst_block", oBlock, 128'd0);
        chk("rst_usedw", 128'(oUsedw), 128'd0);
        chk("rst_cnt", 128'(oBlock_cnt), 128'd0);
        chk("rst_full", 128'(oFull), 128'd0);
        chk("rst_err", 128'(oErr_overflow), 128'd0);

        // Basic block with consumer ready
        iBlock_ready = 1'b1;
        wr(32'h0011_2233); chk("t1_usedw1", 128'(oUsedw), 128'd1);
        wr(32'h4455_6677); chk("t1_usedw2", 128'(oUsedw), 128'd2);
        wr(32'h8899_AABB); chk("t1_usedw3", 128'(oUsedw), 128'd3);
        chk("t1_novalid", 128'(oBlock_valid), 128'd0);
        wr(32'hCCDD_EEFF);
        chk("t1_usedw4", 128'(oUsedw), 128'd4);
        chk("t1_valid", 128'(oBlock_valid), 128'd1);
        chk("t1_block", oBlock, blk(32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF));
        tick();
        chk("t1_usedw0", 128'(oUsedw), 128'd0);
        chk("t1_drop", 128'(oBlock_valid), 128'd0);
        chk("t1_cnt", 128'(oBlock_cnt), 128'd1);

        // Back-pressure: two blocks, one held pending
        iBlock_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(32'h1000_0000 + 32'(i));
            if (i == 4) chk("t2_usedw5", 128'(oUsedw), 128'd5);
        end
        chk("t2_valid", 128'(oBlock_valid), 128'd1);
        chk("t2_full", 128'(oFull), 128'd1);
        chk("t2_usedw8", 128'(oUsedw), 128'd8);
        chk("t2_blockA", oBlock, blk(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003));
        chk("t2_noerr", 128'(oErr_overflow), 128'd0);
        wr(32'hDEAD_BEEF);
        chk("t2_err", 128'(oErr_overflow), 128'd1);
        chk("t2_usedw_hold", 128'(oUsedw), 128'd8);
        chk("t2_blockA_hold", oBlock, blk(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003));
        iBlock_ready = 1'b1;
        tick();
        iBlock_ready = 1'b0;
        chk("t2_unfull", 128'(oFull), 128'd0);
        chk("t2_valid_b", 128'(oBlock_valid), 128'd1);
        chk("t2_blockB", oBlock, blk(32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007));
        chk("t2_usedw4", 128'(oUsedw), 128'd4);
        chk("t2_cnt2", 128'(oBlock_cnt), 128'd2);
        iBlock_ready = 1'b1;
        tick();
        chk("t2_cnt3", 128'(oBlock_cnt), 128'd3);
        chk("t2_drain", 128'(oBlock_valid), 128'd0);
        chk("t2_err_sticky", 128'(oErr_overflow), 128'd1);

        // Soft clear discards a partial block
        wr(32'h5555_0000);
        wr(32'h5555_0001);
        chk("t3_usedw2", 128'(oUsedw), 128'd2);
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        chk("t3_usedw0", 128'(oUsedw), 128'd0);
        chk("t3_err0", 128'(oErr_overflow), 128'd0);
        chk("t3_cnt0", 128'(oBlock_cnt), 128'd0);
        wr(32'h6666_0000);
        wr(32'h6666_0001);
        wr(32'h6666_0002);
        wr(32'h6666_0003);
        chk("t3_block", oBlock, blk(32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003));
        tick();
        chk("t3_cnt1", 128'(oBlock_cnt), 128'd1);

        // Reset wins over the 4th write and handshake
        wr(32'h7777_0000);
        wr(32'h7777_0001);
        wr(32'h7777_0002);
        iWrite = 1'b1;
        iData  = 32'h7777_0003;
        iRst   = 1'b1;
        tick();
        iWrite = 1'b0;
        iRst   = 1'b0;
        chk("t4_valid", 128'(oBlock_valid), 128'd0);
        chk("t4_block", oBlock, 128'd0);
        chk("t4_usedw", 128'(oUsedw), 128'd0);
        chk("t4_cnt", 128'(oBlock_cnt), 128'd0);
        chk("t4_full", 128'(oFull), 128'd0);

        // Repeated word: shows byte order of storage
        for (int i = 0; i < 4; i++) wr(32'h0011_2233);
        chk("bs_block", oBlock, blk(32'h0011_2233, 32'h0011_2233, 32'h0011_2233, 32'h0011_2233));
        tick();
        chk("bs_cnt", 128'(oBlock_cnt), 128'd1);

        // Stream 64 words with toggling ready, writes honour oFull
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while ((sent < 64 || oBlock_valid) && cyc < 1000) begin
            iWrite       = (sent < 64) && !oFull;
            iData        = sw(sent);
            iBlock_ready = (sent >= 64) || cyc[0];
            if (oBlock_valid && iBlock_ready) begin
                chk("t5_block", oBlock, blk(sw(4*rcv), sw(4*rcv+1), sw(4*rcv+2), sw(4*rcv+3)));
                rcv++;
            end
            if (iWrite) sent++;
            tick();
            cyc++;
        end
        iWrite = 1'b0;
        chk("t5_timeout", 128'(cyc < 1000), 128'd1);
        chk("t5_rcv", 128'(rcv), 128'd16);
        chk("t5_cnt", 128'(oBlock_cnt), 128'd17);
        chk("t5_err", 128'(oErr_overflow), 128'd0);
        chk("t5_usedw", 128'(oUsedw), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_word_packer.md
Name: aes_word_packer

Overview:
- Sits between the DMA read-master input FIFO and the AES core datapath.
- Accepts a stream of 32-bit words and assembles each 4 consecutive words into one 128-bit AES block.
- Presents each block on a valid/ready handshake.
- Provides a word-level occupancy count so the read master can throttle outstanding reads.

Parameters:
- DATA_WIDTH, 32, width of each input word; only 32 is supported.
- BLOCK_WIDTH, 128, output block width; must equal 4*DATA_WIDTH.
- CNT_WIDTH, 16, width of the completed-block counter.

Ports:
- iClk  in  1  clock
- iRst  in  1  reset: synchronous, active-high
- iClear  in  1  soft clear from the control register; same effect as iRst
- iWrite  in  1  input word strobe
- iData  in  32  input word
- oFull  out  1  1 = input not accepted this cycle
- oUsedw  out  4  words currently held, 0..8
- oBlock_valid  out  1  output block valid
- oBlock  out  128  assembled block
- iBlock_ready  in  1  consumer accepts the block
- oBlock_cnt  out  CNT_WIDTH  blocks handed off since reset/clear; wraps
- oErr_overflow  out  1  sticky: a write arrived while oFull=1

Behaviour:
- Reset/clear (iRst or iClear high at a clock edge):
  - word index = 0, pending = 0
  - oBlock_valid = 0, oBlock = 0
  - oBlock_cnt = 0, oErr_overflow = 0, oUsedw = 0
  - Any partial or held block is discarded. iClear has priority over a same-cycle iWrite and handshake.
- Assembly register: 128 bits plus a 2-bit word index (0..3).
  - Word k of a block lands in bits [127-32k -: 32]; the first word is the MSW.
- Assembly state machine:
  - FILL: iWrite && !oFull stores the word and increments the index.
  - On the 4th word (index==3), the index wraps to 0:
    - If the output slot is free, or being consumed this cycle (oBlock_valid && iBlock_ready), the block moves to oBlock and oBlock_valid=1 next cycle. State stays FILL.
    - Otherwise the block stays in the assembly register, pending=1, and the state goes to PENDING.
  - PENDING: oFull=1 and no words are accepted. When the slot frees (iBlock_ready while valid), assembly moves to oBlock the same edge, oBlock_valid stays 1, pending=0, and the state returns to FILL.
- oFull is combinational: oFull = pending. It never depends on iWrite.
- Output slot handshake:
  - Transfer occurs when oBlock_valid && iBlock_ready. oBlock_cnt increments on each transfer.
  - oBlock_valid drops next cycle unless a new block loads on the same edge.
  - oBlock is stable while oBlock_valid=1 and not yet accepted.
- Latency: 4th word accepted at edge N gives oBlock_valid=1 after edge N (visible cycle N+1), if the slot is free.
- Throughput: 1 word/cycle sustained when iBlock_ready is held high.
- oUsedw = index + 4*pending + 4*oBlock_valid, registered.
  - Updated on the same edges as the state it reflects.
  - Max 8: pending block plus output block.
- Write while oFull=1: the word is dropped, oErr_overflow=1 until reset/clear, and no other state changes.
- oBlock_cnt wraps from 2^CNT_WIDTH-1 to 0.

Optional Feature:
- Macro: AES_PACK_BYTESWAP_EN.
- Defined: each input word is byte-reversed before storage ({b0,b1,b2,b3}), for little-endian host buffers.
- Undefined: words are stored unchanged.
- Word ordering within the block is identical in both cases.

Decomposition:
- Package aes_pkg holds:
  - AES_BLOCK_WIDTH=128
  - AES_WORD_WIDTH=32
  - AES_WORDS_PER_BLOCK=4
  - the FILL/PENDING state encoding
  - the byte-swap function
- One sub-module: aes_block_slot, a single-entry 128-bit valid/ready holding register with load/accept/count logic. It is instantiated once for the output slot.

Test Plan:
- Write 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles with iBlock_ready=1 -> oBlock=0x00112233_44556677_8899AABB_CCDDEEFF, valid one cycle after the 4th word; oBlock_cnt=1; oUsedw sequence 1,2,3,4,0.
- iBlock_ready=0, write 8 words -> oBlock_valid=1 and oFull=1 after the 8th word, oUsedw=8. Then a 9th write -> dropped, oErr_overflow=1. Then raise ready for 1 cycle -> block 2 moves to oBlock and oFull=0 next cycle.
- Write 2 words then iClear=1 -> oUsedw=0; then 4 new words give a block containing only the new words.
- Assert iRst in the same cycle as the 4th write and ready -> all outputs 0 next cycle, oBlock_cnt=0.
- Stream 64 words with iBlock_ready toggling every other cycle -> 16 blocks in order, no loss, oErr_overflow=0 when writes respect oFull.
- With AES_PACK_BYTESWAP_EN defined, write 0x00112233 x4 -> oBlock=0x33221100 repeated 4 times.
